// File: rtl/fe_mul_arb_pkg.sv
// Shared types and widths for the fe_mul arbiter.
package fe_mul_arb_pkg;

  localparam int unsigned FE_WIDTH = 320;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } fe_mul_arb_state_t;

endpackage

// File: rtl/fe_mul_arb_grant.sv
// Winner selection for the fe_mul arbiter: fixed lowest-index priority by default,
// round-robin with a pointer register when FE_MUL_ARB_RR_EN is defined.
module fe_mul_arb_grant #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef FE_MUL_ARB_RR_EN
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    grant_idx,
  output logic               grant_any
);

`ifdef FE_MUL_ARB_RR_EN
  logic [IdxW-1:0] ptr_q;
  int unsigned     j;

  // Search wraps from the pointer so the last winner gets lowest priority next time.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_any && req_valid[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IdxW'(j);
        grant_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[k]) begin
        grant[k]  = 1'b1;
        grant_idx = IdxW'(k);
        grant_any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fe_mul_arbiter.sv
// Shares one fe_mul among NUM_REQ requesters; one multiplication in flight at a time.
// Round-robin arbitration when FE_MUL_ARB_RR_EN is defined, else fixed lowest-index priority.
module fe_mul_arbiter
  import fe_mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = FE_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_f,
  input  logic [NUM_REQ*WIDTH-1:0] req_g,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_h,
  output logic                     busy,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_f,
  output logic [WIDTH-1:0]         mul_g,
  input  logic                     mul_done,
  input  logic [WIDTH-1:0]         mul_h
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  fe_mul_arb_state_t state_q, state_d;
  logic [IdxW-1:0]   owner_q;
  logic [WIDTH-1:0]  op_f_q, op_g_q, rsp_h_q;
  logic [WIDTH-1:0]  sel_f, sel_g;
  logic [NUM_REQ-1:0] grant;
  logic [IdxW-1:0]   grant_idx;
  logic              grant_any;
  logic              arb_en;
  logic              accept;

  fe_mul_arb_grant #(
    .NUM_REQ(NUM_REQ)
  ) u_grant (
    .req_valid(req_valid),
`ifdef FE_MUL_ARB_RR_EN
    .clk      (clk),
    .reset    (reset),
    .advance  (accept),
`endif
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_any(grant_any)
  );

  assign arb_en = (state_q == StIdle) || (state_q == StResp);
  assign accept = arb_en && grant_any;

  always_comb begin
    sel_f = '0;
    sel_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_f = req_f[i*WIDTH +: WIDTH];
        sel_g = req_g[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (mul_done) state_d = StResp;
      StResp:  state_d = accept ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      op_f_q  <= '0;
      op_g_q  <= '0;
      rsp_h_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant_idx;
        op_f_q  <= sel_f;
        op_g_q  <= sel_g;
      end
      // mul_done outside WAIT is a stray pulse and must not disturb the result.
      if (state_q == StWait && mul_done) begin
        rsp_h_q <= mul_h;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == StResp) && (owner_q == IdxW'(i));
    end
  end

  assign req_ready = arb_en ? grant : '0;
  assign busy      = (state_q != StIdle);
  assign mul_start = (state_q == StIssue);
  assign mul_f     = op_f_q;
  assign mul_g     = op_g_q;
  assign rsp_h     = rsp_h_q;

endmodule

// File: doc/fe_mul_arbiter.md
# fe_mul_arbiter

Shares one `fe_mul` field multiplier among `NUM_REQ` requesters, such as the point-arithmetic sequencers (p1p1→p3 and p1p1→p2 conversion, point doubling and addition). Each requester presents an operand pair through a valid/ready handshake. The arbiter grants one requester, captures its operands and drives the multiplier's start/done handshake. It returns the product with a per-requester response pulse. Only one multiplication is in flight at any time.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `WIDTH`, default 320: operand width, signed field element (10×32-bit limbs).

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: requester i has an operand pair pending.
- `req_f`  in  NUM_REQ*WIDTH: flattened operand f; slice i is `[i*WIDTH +: WIDTH]`.
- `req_g`  in  NUM_REQ*WIDTH: flattened operand g, same packing as `req_f`.
- `req_ready`  out  NUM_REQ: one-hot accept; a transfer occurs on the edge where `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  NUM_REQ: one-hot, one-cycle pulse; `rsp_h` is valid for requester i.
- `rsp_h`  out  WIDTH: signed product; holds its value until the next response.
- `busy`  out  1: high in every state except IDLE.
- `mul_start`  out  1: one-cycle start pulse to `fe_mul`.
- `mul_f`, `mul_g`  out  WIDTH: operands to `fe_mul`, held stable from ISSUE through WAIT.
- `mul_done`  in  1: completion pulse from `fe_mul`.
- `mul_h`  in  WIDTH: product from `fe_mul`, sampled while `mul_done` is high.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **Arbitration.** Arbitration runs in IDLE and in RESP. `req_ready` is combinational: at most one bit is high, only in IDLE or RESP, and only for the winning requester with `req_valid` high.
- **Accept edge.** On the accept edge the arbiter:
  - latches `req_f[i]` and `req_g[i]` into the operand registers;
  - records owner = i;
  - updates the priority pointer;
  - moves to ISSUE.
- **Requester rules.** A requester must hold `req_valid` and its operands stable until it sees `req_ready`. It may change its operands on the cycle after acceptance.
- **ISSUE** (always one cycle): `mul_start` = 1, `mul_f`/`mul_g` = operand registers; then WAIT.
- **WAIT:** hold the operands until `mul_done` = 1, then latch `mul_h` into `rsp_h` and go to RESP.
- **RESP** (one cycle): `rsp_valid[owner]` = 1. If any request is pending, accept it and go to ISSUE; otherwise go to IDLE.
- **Ignored `mul_done`:** a `mul_done` in IDLE, ISSUE or RESP is ignored; it does not change `rsp_h`, state or outputs.
- **Re-request by the owner:** the owner may re-request during its own RESP cycle and competes normally.
- **Widths:** no arithmetic is performed on the data; it passes through at full WIDTH with sign preserved.

## Timing
- **Reset values:**
  - state = IDLE, owner = 0, priority pointer = 0;
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_h` = 0, `busy` = 0;
  - `mul_start` = 0, `mul_f` = 0, `mul_g` = 0.
- **Latency.** Take the accept edge as the end of cycle T and let `fe_mul` assert done D cycles after start:
  - `mul_start` is high in cycle T+1;
  - `mul_done` is sampled in cycle T+1+D;
  - `rsp_valid` pulses in cycle T+2+D.
- **Throughput.** Back-to-back accepts in RESP give one multiplication per D+2 cycles.
- **Reset mid-operation.** Reset returns the block to IDLE and zeroes all outputs. The in-flight product is discarded; any later `mul_done` arrives in IDLE and is ignored.
- **Simultaneous requests:** resolved by the priority rule in Configuration.
- **Request during ISSUE or WAIT:** `req_ready` stays 0 and the request waits.

## Configuration
- `FE_MUL_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at the priority pointer; after a grant to i, pointer = (i+1) mod NUM_REQ.
  - Guarantees no starvation.
- Not defined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package `fe_mul_arb_pkg`: `fe_mul_arb_state_t` enum (IDLE, ISSUE, WAIT, RESP) and localparam `FE_WIDTH = 320`.
- Sub-module `fe_mul_arb_grant`: combinational winner selection from `req_valid` and the pointer, plus the pointer register under `FE_MUL_ARB_RR_EN`. It outputs a one-hot grant and the encoded index.
- Top level: FSM, operand and result registers, response decode.

## Test plan
Bench mock `fe_mul` returns f*g with D = 5.
- **Single request:** `req_valid[2]`, f=3, g=7.
  - `req_ready[2]` is high in the same cycle; `mul_start` follows one cycle later.
  - `rsp_valid[2]` pulses exactly 7 cycles after the accept edge with `rsp_h`=21; `busy` then drops.
- **All four requesting** with f=i+1, g=10:
  - with `FE_MUL_ARB_RR_EN`: grant order 0,1,2,3, responses 10,20,30,40, each 7 cycles apart;
  - without the macro and with requester 0 re-asserting: requester 0 wins every arbitration and requester 1 waits.
- **Operand capture:** requester changes `req_f` to 0 the cycle after accept with f=−5, g=4 → `rsp_h`=−20 and `mul_f` stays −5 through WAIT.
- **Spurious `mul_done`** pulsed in IDLE and ISSUE → no `rsp_valid` and `rsp_h` unchanged.
- **Reset mid-operation:** reset asserted in cycle 3 of WAIT → all outputs 0 next cycle; the mock's late `mul_done` is ignored and a new request then completes normally.
